// File: rtl/clock_control.sv
// clock_control: turns divider ticks into a single-cycle CPU clock enable with
// run, single-step and halt/resume modes. Step-button debounce is enabled by CLKCTL_DEBOUNCE_EN.
module clock_control #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             run_mode,
    input  logic             step_btn,
    input  logic             halt,
    input  logic             resume,
    output logic             cpu_ce,
    output logic             cpu_clk,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt
);

    // state     | meaning
    // ST_RUN    | cpu_ce follows tick
    // ST_STEP   | cpu_ce follows accepted button presses
    // ST_HALTED | cpu_ce held low until resume with halt released
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_STEP   = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    if (DB_CYCLES < 2) begin : g_db_cycles_check
        $error("clock_control: DB_CYCLES must be at least 2");
    end

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       btn_db;
    logic       btn_prev_q, btn_prev_d;
    logic       step_req_q, step_req_d;
    logic       resume_q, resume_d;
    logic       resume_req;
    logic [1:0] state_q, state_d;
    logic       cpu_ce_q, cpu_ce_d;
    logic       cpu_clk_q, cpu_clk_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

    always_comb begin
        sync1_d = step_btn;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

`ifdef CLKCTL_DEBOUNCE_EN
    localparam int DB_W = $clog2(DB_CYCLES + 1);

    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            btn_db_q, btn_db_d;

    // Counter only runs while the synchronised level disagrees; any agreement restarts it.
    always_comb begin
        db_cnt_d = '0;
        btn_db_d = btn_db_q;
        if (sync2_q != btn_db_q) begin
            if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
                btn_db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
            btn_db_q <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            btn_db_q <= btn_db_d;
        end
    end

    assign btn_db = btn_db_q;
`else
    assign btn_db = sync2_q;
`endif

    always_comb begin
        btn_prev_d = btn_db;
        step_req_d = btn_db & ~btn_prev_q;
        resume_d   = resume;
        resume_req = resume & ~resume_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_prev_q <= 1'b0;
            step_req_q <= 1'b0;
            resume_q   <= 1'b0;
        end else begin
            btn_prev_q <= btn_prev_d;
            step_req_q <= step_req_d;
            resume_q   <= resume_d;
        end
    end

    // halt overrides everything, including a tick or step request in the same cycle.
    always_comb begin
        state_d  = state_q;
        cpu_ce_d = 1'b0;
        if (halt) begin
            state_d = ST_HALTED;
        end else begin
            case (state_q)
                ST_RUN: begin
                    cpu_ce_d = tick;
                    state_d  = run_mode ? ST_RUN : ST_STEP;
                end
                ST_STEP: begin
                    cpu_ce_d = step_req_q;
                    state_d  = run_mode ? ST_RUN : ST_STEP;
                end
                ST_HALTED: begin
                    if (resume_req) begin
                        state_d = run_mode ? ST_RUN : ST_STEP;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_comb begin
        cpu_clk_d   = cpu_clk_q ^ cpu_ce_d;
        cycle_cnt_d = cycle_cnt_q + {{(CNT_W-1){1'b0}}, cpu_ce_d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            cpu_ce_q    <= 1'b0;
            cpu_clk_q   <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cpu_ce_q    <= cpu_ce_d;
            cpu_clk_q   <= cpu_clk_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign cpu_ce    = cpu_ce_q;
    assign cpu_clk   = cpu_clk_q;
    assign halted    = (state_q == ST_HALTED);
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_clock_control.sv
// Randomised scoreboard bench for clock_control against a behavioural model.
module tb_clock_control;

    localparam int DB = 16;
    localparam int CW = 8;
`ifdef CLKCTL_DEBOUNCE_EN
    localparam int ACCEPT_RUN = DB;
    localparam int PRESS_LAT  = 2 + DB + 1 + 1;
`else
    localparam int ACCEPT_RUN = 1;
    localparam int PRESS_LAT  = 2 + 1 + 1;
`endif
    // edges between the last raw sample that completes a press and the cpu_ce it produces
    localparam int STEP_DLY = PRESS_LAT - ACCEPT_RUN;

    logic          clk;
    logic          rst_n, tick, run_mode, step_btn, halt, resume;
    logic          cpu_ce, cpu_clk, halted;
    logic [CW-1:0] cycle_cnt;

    clock_control #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .run_mode  (run_mode),
        .step_btn  (step_btn),
        .halt      (halt),
        .resume    (resume),
        .cpu_ce    (cpu_ce),
        .cpu_clk   (cpu_clk),
        .halted    (halted),
        .cycle_cnt (cycle_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          due;
        bit          ce;
        bit          ck;
        bit          hl;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   ce_seen = 0;
    int   last_ce_cyc = 0;

    // behavioural model state
    bit   m_run, m_halted, m_clk, m_ce, m_prev_res;
    int   m_cnt;
    bit   m_raw_val, m_accepted;
    int   m_raw_len;
    int   m_step_at[$];

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic model_reset();
        m_run      = 1'b1;
        m_halted   = 1'b0;
        m_clk      = 1'b0;
        m_ce       = 1'b0;
        m_prev_res = 1'b0;
        m_cnt      = 0;
        m_raw_val  = 1'b0;
        m_raw_len  = 0;
        m_accepted = 1'b0;
        m_step_at.delete();
    endtask

    // Applies the rules at clock edge e using the inputs currently driven.
    task automatic model_edge(input int e);
        bit sreq;
        bit rreq;
        if (!rst_n) begin
            model_reset();
        end else begin
            sreq = 1'b0;
            if (m_step_at.size() > 0 && m_step_at[0] == e) begin
                sreq = 1'b1;
                void'(m_step_at.pop_front());
            end
            rreq = resume && !m_prev_res;
            m_prev_res = resume;
            m_ce = 1'b0;
            if (halt) begin
                m_halted = 1'b1;
            end else if (m_halted) begin
                if (rreq) begin
                    m_halted = 1'b0;
                    m_run    = run_mode;
                end
            end else begin
                m_ce  = m_run ? tick : sreq;
                m_run = run_mode;
            end
            if (m_raw_len > 0 && step_btn == m_raw_val) begin
                m_raw_len++;
            end else begin
                m_raw_val = step_btn;
                m_raw_len = 1;
            end
            if (m_raw_len == ACCEPT_RUN && m_raw_val != m_accepted) begin
                m_accepted = m_raw_val;
                if (m_raw_val) m_step_at.push_back(e + STEP_DLY);
            end
            if (m_ce) begin
                m_clk = !m_clk;
                m_cnt = (m_cnt + 1) % (1 << CW);
            end
        end
    endtask

    task automatic cycle();
        exp_t e;
        model_edge(cyc + 1);
        e.due = cyc + 1;
        e.ce  = m_ce;
        e.ck  = m_clk;
        e.hl  = m_halted;
        e.cnt = CW'(m_cnt);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // monitor: pops the expected response for every edge the DUT has completed
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                n_vec++;
                if ({cpu_ce, cpu_clk, halted, cycle_cnt} !== {e.ce, e.ck, e.hl, e.cnt}) begin
                    n_bad++;
                    $display("FAIL edge %0d ce/clk/halted/cnt: got %b/%b/%b/%0d, expected %b/%b/%b/%0d",
                             e.due, cpu_ce, cpu_clk, halted, cycle_cnt, e.ce, e.ck, e.hl, e.cnt);
                end
            end
            if (cpu_ce === 1'b1) begin
                ce_seen++;
                last_ce_cyc = cyc;
            end
        end
    end

    initial begin
        int last_edge;
        int btn_rate;
        model_reset();
        rst_n = 1'b0; tick = 1'b0; run_mode = 1'b1;
        step_btn = 1'b0; halt = 1'b0; resume = 1'b0;

        // reset with tick toggling
        for (int i = 0; i < 3; i++) begin
            tick = i[0];
            cycle();
        end
        check("reset_outputs", int'({cpu_ce, cpu_clk, halted, cycle_cnt}), 0);

        // free run, tick every 4th cycle
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick = (i % 4 == 0);
            cycle();
        end
        check("run_count", int'(cycle_cnt), 10);

        // single step with a bouncy press
        run_mode = 1'b0;
        tick = 1'b0;
        cycle();
        ce_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step_btn = 1'b1; tick = 1'($urandom_range(0, 1)); cycle();
            step_btn = 1'b0; tick = 1'($urandom_range(0, 1)); cycle();
        end
        step_btn = 1'b1;
        last_edge = cyc + 1;
        for (int i = 0; i < 40; i++) begin
            tick = 1'($urandom_range(0, 1));
            cycle();
        end
`ifdef CLKCTL_DEBOUNCE_EN
        check("step_single_pulse", ce_seen, 1);
`endif
        check("step_latency", last_ce_cyc - (last_edge - 1), PRESS_LAT);
        step_btn = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick = 1'($urandom_range(0, 1));
            cycle();
        end

        // halt priority and resume handling
        run_mode = 1'b1; tick = 1'b0;
        cycle(); cycle();
        tick = 1'b1; halt = 1'b1;
        cycle();
        check("halt_prio_ce", int'(cpu_ce), 0);
        check("halt_prio_halted", int'(halted), 1);
        tick = 1'b0;
        cycle(); cycle();
        resume = 1'b1; cycle();
        resume = 1'b0; cycle();
        check("resume_while_halt", int'(halted), 1);
        halt = 1'b0;
        cycle(); cycle();
        resume = 1'b1; cycle();
        check("resume_exit", int'(halted), 0);
        for (int i = 0; i < 12; i++) begin
            tick = (i % 3 == 1);
            cycle();
        end
        resume = 1'b0;

        // counter wrap after 256 enables from reset
        rst_n = 1'b0; tick = 1'b0;
        cycle(); cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tick = 1'b1; cycle();
            tick = 1'b0; cycle();
        end
        check("wrap_cnt", int'(cycle_cnt), 0);
        check("wrap_clk", int'(cpu_clk), 0);

        // press accepted in run mode is discarded
        ce_seen = 0;
        step_btn = 1'b1;
        for (int i = 0; i < 30; i++) cycle();
        run_mode = 1'b0;
        for (int i = 0; i < 30; i++) cycle();
        check("no_step_from_run", ce_seen, 0);
        step_btn = 1'b0;
        for (int i = 0; i < 25; i++) cycle();
        ce_seen = 0;
        step_btn = 1'b1;
        for (int i = 0; i < 25; i++) cycle();
        check("fresh_press", ce_seen, 1);

        // randomised soak
        btn_rate = 8;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0: btn_rate = 2;
                    1: btn_rate = 8;
                    default: btn_rate = 40;
                endcase
            end
            rst_n = ($urandom_range(0, 299) != 0);
            tick  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) run_mode = !run_mode;
            if ($urandom_range(0, btn_rate - 1) == 0) step_btn = !step_btn;
            if ($urandom_range(0, 39) == 0) halt = !halt;
            if ($urandom_range(0, 4) == 0) resume = !resume;
            cycle();
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
            #5;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expected responses never checked, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
